// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared RedMulE array constants and tile sequencer types
package redmule_pkg;

  localparam int unsigned ARRAY_WIDTH  = 12;
  localparam int unsigned ARRAY_HEIGHT = 4;
  localparam int unsigned PIPE_REGS    = 3;
  localparam int unsigned TILE_CNT_W   = 16;
  localparam int unsigned TILE_SIZE_W  = 8;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_LOAD = 2'd1,
    TS_RUN  = 2'd2,
    TS_DONE = 2'd3
  } tile_seq_state_e;

  typedef struct packed {
    logic [TILE_CNT_W-1:0]  x_row;
    logic [TILE_CNT_W-1:0]  w_col;
    logic [TILE_CNT_W-1:0]  x_col;
    logic [TILE_SIZE_W-1:0] rows;
    logic [TILE_SIZE_W-1:0] cols;
    logic [TILE_SIZE_W-1:0] depth;
    logic                   first;
    logic                   last;
  } tile_desc_t;

  // A nonzero leftover only shrinks the final tile along its dimension.
  function automatic logic [TILE_SIZE_W-1:0] tile_size(input logic                   is_last,
                                                       input logic [TILE_SIZE_W-1:0] lftovr,
                                                       input logic [TILE_SIZE_W-1:0] full);
    return (is_last && (lftovr != '0)) ? lftovr : full;
  endfunction

endpackage

// File: rtl/redmule_tile_counter.sv
// rtl/redmule_tile_counter.sv - bounded loop counter; nxt_o is the value loaded on the next edge
module redmule_tile_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] bound_i,
  output logic [CNT_W-1:0] nxt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             at_last;

  assign at_last = (cnt_q == (bound_i - CNT_W'(1)));
  assign wrap_o  = en_i & at_last;

  always_comb begin
    nxt_o = cnt_q;
    if (clr_i)        nxt_o = '0;
    else if (wrap_o)  nxt_o = '0;
    else if (en_i)    nxt_o = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= nxt_o;
  end

endmodule

// File: rtl/redmule_tile_sequencer.sv
// rtl/redmule_tile_sequencer.sv - walks the tiler GEMM loop nest as tile descriptors
// Optional stall counter: define REDMULE_TILE_SEQ_STALL_CNT_EN.
module redmule_tile_sequencer #(
  parameter int unsigned ARRAY_WIDTH  = redmule_pkg::ARRAY_WIDTH,
  parameter int unsigned ARRAY_HEIGHT = redmule_pkg::ARRAY_HEIGHT,
  parameter int unsigned PIPE_REGS    = redmule_pkg::PIPE_REGS,
  parameter int unsigned CNT_W        = redmule_pkg::TILE_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] x_rows_iter_i,
  input  logic [CNT_W-1:0] w_cols_iter_i,
  input  logic [CNT_W-1:0] x_cols_iter_i,
  input  logic [7:0]       x_rows_lftovr_i,
  input  logic [7:0]       w_cols_lftovr_i,
  input  logic [7:0]       x_cols_lftovr_i,
  input  logic [15:0]      tot_stores_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [CNT_W-1:0] tile_x_row_o,
  output logic [CNT_W-1:0] tile_w_col_o,
  output logic [CNT_W-1:0] tile_x_col_o,
  output logic [7:0]       tile_rows_o,
  output logic [7:0]       tile_cols_o,
  output logic [7:0]       tile_depth_o,
  output logic             tile_first_o,
  output logic             tile_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      stall_cnt_o
);
  import redmule_pkg::*;

  localparam logic [1:0] S_IDLE = TS_IDLE;
  localparam logic [1:0] S_LOAD = TS_LOAD;
  localparam logic [1:0] S_RUN  = TS_RUN;
  localparam logic [1:0] S_DONE = TS_DONE;
  localparam logic [7:0] FULL_ROWS = 8'(ARRAY_WIDTH);
  localparam logic [7:0] FULL_COLS = 8'(ARRAY_HEIGHT * (PIPE_REGS + 1));

  logic [1:0]       state_q;
  logic             valid_q;
  tile_desc_t       desc_q, desc_d;
  logic [CNT_W-1:0] xr_bnd_q, wc_bnd_q, xc_bnd_q;
  logic [7:0]       xr_lo_q, wc_lo_q, xc_lo_q;
  logic [15:0]      tot_q, stores_q;
  logic [CNT_W-1:0] xr_nxt, wc_nxt, xc_nxt;
  logic             xr_wrap, wc_wrap, xc_wrap;
  logic             start_acc, hs, cnt_clr, zero_iter;

  assign start_acc = (state_q == S_IDLE) & start_i & cfg_valid_i & ~clear_i;
  assign hs        = valid_q & tile_ready_i;
  assign cnt_clr   = clear_i | start_acc;
  assign zero_iter = (xr_bnd_q == '0) | (wc_bnd_q == '0) | (xc_bnd_q == '0);

  // x_col innermost; each wrap steps the next-outer counter.
  redmule_tile_counter #(.CNT_W(CNT_W)) u_x_col (
    .clk_i, .rst_ni, .clr_i(cnt_clr), .en_i(hs),
    .bound_i(xc_bnd_q), .nxt_o(xc_nxt), .wrap_o(xc_wrap)
  );
  redmule_tile_counter #(.CNT_W(CNT_W)) u_w_col (
    .clk_i, .rst_ni, .clr_i(cnt_clr), .en_i(xc_wrap),
    .bound_i(wc_bnd_q), .nxt_o(wc_nxt), .wrap_o(wc_wrap)
  );
  redmule_tile_counter #(.CNT_W(CNT_W)) u_x_row (
    .clk_i, .rst_ni, .clr_i(cnt_clr), .en_i(wc_wrap),
    .bound_i(xr_bnd_q), .nxt_o(xr_nxt), .wrap_o(xr_wrap)
  );

  always_comb begin
    desc_d       = '0;
    desc_d.x_row = xr_nxt;
    desc_d.w_col = wc_nxt;
    desc_d.x_col = xc_nxt;
    desc_d.rows  = tile_size(xr_nxt == (xr_bnd_q - CNT_W'(1)), xr_lo_q, FULL_ROWS);
    desc_d.cols  = tile_size(wc_nxt == (wc_bnd_q - CNT_W'(1)), wc_lo_q, FULL_COLS);
    desc_d.depth = tile_size(xc_nxt == (xc_bnd_q - CNT_W'(1)), xc_lo_q, FULL_COLS);
    desc_d.first = (xc_nxt == '0);
    desc_d.last  = (xc_nxt == (xc_bnd_q - CNT_W'(1)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      desc_q   <= '0;
      xr_bnd_q <= '0;
      wc_bnd_q <= '0;
      xc_bnd_q <= '0;
      xr_lo_q  <= '0;
      wc_lo_q  <= '0;
      xc_lo_q  <= '0;
      tot_q    <= '0;
      stores_q <= '0;
    end else if (clear_i) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      desc_q   <= '0;
      stores_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_acc) begin
          xr_bnd_q <= x_rows_iter_i;
          wc_bnd_q <= w_cols_iter_i;
          xc_bnd_q <= x_cols_iter_i;
          xr_lo_q  <= x_rows_lftovr_i;
          wc_lo_q  <= w_cols_lftovr_i;
          xc_lo_q  <= x_cols_lftovr_i;
          tot_q    <= tot_stores_i;
          stores_q <= '0;
          state_q  <= S_LOAD;
        end
        S_LOAD: if (zero_iter) begin
          state_q <= S_IDLE;
        end else begin
          valid_q <= 1'b1;
          desc_q  <= desc_d;
          state_q <= S_RUN;
        end
        S_RUN: if (hs) begin
          if (desc_q.last) stores_q <= stores_q + 16'd1;
          if (xr_wrap) begin
            valid_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            desc_q <= desc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 stall_q <= '0;
    else if (cnt_clr)                            stall_q <= '0;
    else if ((state_q == S_RUN) && valid_q && !tile_ready_i && (stall_q != '1))
                                                 stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign tile_valid_o = valid_q;
  assign tile_x_row_o = desc_q.x_row;
  assign tile_w_col_o = desc_q.w_col;
  assign tile_x_col_o = desc_q.x_col;
  assign tile_rows_o  = desc_q.rows;
  assign tile_cols_o  = desc_q.cols;
  assign tile_depth_o = desc_q.depth;
  assign tile_first_o = desc_q.first;
  assign tile_last_o  = desc_q.last;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE) & ~clear_i;
  assign err_o        = ~clear_i & (((state_q == S_LOAD) & zero_iter) |
                                    ((state_q == S_DONE) & (stores_q != tot_q)));

endmodule
